load_use_scoreboard: RTL



---
 rtl/hazard_pkg.sv | 24 ++
 rtl/hazard_src_decode.sv | 30 +++
 rtl/load_use_scoreboard.sv | 129 ++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the load-use hazard controller.
//   - RV32 base opcodes used by source-register decode
//   - LOAD_LAT_MAX: largest supported load-to-forward latency
//   - src_use_t: which source-register fields an instruction reads
package hazard_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam int LOAD_LAT_MAX = 15;

    typedef struct packed {
        logic usesRs1;
        logic usesRs2;
    } src_use_t;

endpackage

// File: rtl/hazard_src_decode.sv
// hazard_src_decode: purely combinational map from an RV32 opcode to the
// source-register fields the instruction actually reads.
// Ports:
//   opCode  in  7  instruction opcode
//   usesRs1 out 1  rs1 field is a real source
//   usesRs2 out 1  rs2 field is a real source
module hazard_src_decode
    import hazard_pkg::*;
(
    input  logic [6:0] opCode,
    output logic       usesRs1,
    output logic       usesRs2
);

    src_use_t use_s;

    // Opcode to source-usage table; unknown opcodes read rs1 only.
    always_comb begin
        use_s = '{usesRs1: 1'b1, usesRs2: 1'b0};
        case (opCode)
            OPC_LUI, OPC_AUIPC, OPC_JAL: use_s = '{usesRs1: 1'b0, usesRs2: 1'b0};
            OPC_OP, OPC_STORE, OPC_BRANCH: use_s = '{usesRs1: 1'b1, usesRs2: 1'b1};
            default: use_s = '{usesRs1: 1'b1, usesRs2: 1'b0};
        endcase
    end

    assign usesRs1 = use_s.usesRs1;
    assign usesRs2 = use_s.usesRs2;

endmodule

// File: rtl/load_use_scoreboard.sv
// load_use_scoreboard: load-use hazard controller between ID and EX.
// Each architectural register (except x0) has a small countdown that holds
// how many more ready cycles a recently accepted load still needs before its
// data can be forwarded. A used ID source matching either the load currently
// in EX or a nonzero countdown raises a stall. mem_ready_i=0 freezes the pipe
// and the scoreboard.
// Parameters: REG_ADDR_W (address width), LOAD_LAT (1..LOAD_LAT_MAX),
//             CNT_W (stall-counter width).
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   ID_valid_i/opCode/rs/rt      instruction in ID
//   EX_valid_i/memRead/wbAddr    instruction in EX
//   mem_ready_i                  data memory ready (0 = freeze)
//   hazardDetected_o, bubble_o   stall PC/IF-ID and inject a NOP
//   freeze_o                     hold all pipeline registers
//   stallCount_o                 number of hazard cycles (saturating)
// Optional feature macro: HAZARD_STALL_CNT_EN enables the stall counter;
// otherwise stallCount_o is tied to zero.
module load_use_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ID_valid_i,
    input  logic [6:0]            ID_opCode_i,
    input  logic [REG_ADDR_W-1:0] ID_rsAddr_i,
    input  logic [REG_ADDR_W-1:0] ID_rtAddr_i,
    input  logic                  EX_valid_i,
    input  logic                  EX_memRead_i,
    input  logic [REG_ADDR_W-1:0] EX_wbAddr_i,
    input  logic                  mem_ready_i,
    output logic                  hazardDetected_o,
    output logic                  bubble_o,
    output logic                  freeze_o,
    output logic [CNT_W-1:0]      stallCount_o
);

    localparam int NUM_REGS = 1 << REG_ADDR_W;
    localparam int SB_W     = $clog2(LOAD_LAT + 1);
    // The EX-stage compare covers the first stall cycle, so the countdown
    // only needs to cover the remaining LOAD_LAT-1 cycles.
    localparam logic [SB_W-1:0] LOAD_INIT = SB_W'(LOAD_LAT - 1);

    logic                usesRs1_s;
    logic                usesRs2_s;
    logic                exLoad_s;
    logic                loadAccept_s;
    logic [NUM_REGS-1:0] pending_s;
    logic                match_s;
    logic                hazard_s;
    logic [SB_W-1:0]     cnt_r [1:NUM_REGS-1];

    hazard_src_decode u_srcDecode (
        .opCode  (ID_opCode_i),
        .usesRs1 (usesRs1_s),
        .usesRs2 (usesRs2_s)
    );

    assign exLoad_s     = EX_valid_i & EX_memRead_i;
    assign loadAccept_s = exLoad_s & (EX_wbAddr_i != {REG_ADDR_W{1'b0}}) & mem_ready_i;

    // Scoreboard countdowns: a new load overrides any decrement of its register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                cnt_r[r] <= {SB_W{1'b0}};
            end
        end else if (mem_ready_i) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (loadAccept_s && (EX_wbAddr_i == REG_ADDR_W'(r))) begin
                    cnt_r[r] <= LOAD_INIT;
                end else if (cnt_r[r] != {SB_W{1'b0}}) begin
                    cnt_r[r] <= cnt_r[r] - SB_W'(1);
                end else begin
                    cnt_r[r] <= cnt_r[r];
                end
            end
        end
    end

    // Per-register "not yet forwardable" flags; x0 is never pending.
    always_comb begin
        pending_s = {NUM_REGS{1'b0}};
        for (int r = 1; r < NUM_REGS; r++) begin
            pending_s[r] = (cnt_r[r] != {SB_W{1'b0}}) ||
                           (exLoad_s && (EX_wbAddr_i == REG_ADDR_W'(r)));
        end
    end

    assign match_s = (usesRs1_s & pending_s[ID_rsAddr_i]) |
                     (usesRs2_s & pending_s[ID_rtAddr_i]);

    // Hazard is suppressed while frozen or in reset.
    always_comb begin
        if (!rst_i && ID_valid_i && mem_ready_i) begin
            hazard_s = match_s;
        end else begin
            hazard_s = 1'b0;
        end
    end

    assign hazardDetected_o = hazard_s;
    assign bubble_o         = hazard_s;
    assign freeze_o         = ~rst_i & ~mem_ready_i;

`ifdef HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] stallCnt_r;

    // Saturating count of hazard cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stallCnt_r <= {CNT_W{1'b0}};
        end else if (hazard_s && (stallCnt_r != {CNT_W{1'b1}})) begin
            stallCnt_r <= stallCnt_r + CNT_W'(1);
        end else begin
            stallCnt_r <= stallCnt_r;
        end
    end

    assign stallCount_o = rst_i ? {CNT_W{1'b0}} : stallCnt_r;
`else
    assign stallCount_o = {CNT_W{1'b0}};
`endif

endmodule
